spi_master_engine: RTL

Parametrised SPI master that generalises the current single-byte, Mode-0-only master path. It supports all four SPI modes, a configurable frame width, multi-frame bursts under a single CS assertion, a runtime clock divider and multiple chip selects. It sits between the CSR/bus-side controller, which feeds frames via a valid/ready handshake, and the SPI pads, which are driven through the existing tri-state buffers. Interrupt logic is supplied by the pulse outputs.

---
 rtl/spi_master_engine.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/spi_master_engine.sv
// SPI master: four modes, burst frames under one CS, runtime SCK divider.
// One-entry holding buffer in front of the shifter keeps bursts gapless.
module spi_master_engine #(
  parameter int pDataWidth = 8,
  parameter int pCsNum     = 2,
  parameter int pDivWidth  = 8,
  parameter int pLenWidth  = 12,
  parameter int pCsWidth   = (pCsNum > 1) ? $clog2(pCsNum) : 1
) (
  input  logic                  iSysClk,
  input  logic                  iSysRst,
  input  logic                  iSpiEn,
  input  logic                  iCpol,
  input  logic                  iCpha,
  input  logic [pDivWidth-1:0]  iDiv,
  input  logic [pCsWidth-1:0]   iCsSel,
  input  logic [pLenWidth-1:0]  iLen,
  input  logic [pDataWidth-1:0] iWd,
  input  logic                  iWdVd,
  output logic                  oWdRdy,
  output logic [pDataWidth-1:0] oRd,
  output logic                  oRdVd,
  output logic                  oBusy,
  output logic                  oDone,
  output logic                  oSck,
  output logic                  oMosi,
  input  logic                  iMiso,
  output logic [pCsNum-1:0]     oCs
);

  localparam int cEdgeW = $clog2(2 * pDataWidth);
  localparam logic [cEdgeW-1:0] cLastEdge =
    cEdgeW'(2 * pDataWidth - 1);

  typedef enum logic [2:0] {
    sIdle, sSetup, sXfer, sStall, sHold
  } state_t;

  state_t                state;
  logic                  bufFull;
  logic [pDataWidth-1:0] bufData;
  logic [pDataWidth-1:0] txSh;
  logic [pDataWidth-1:0] rxSh;
  logic [cEdgeW-1:0]     edgeCnt;
  logic [pDivWidth-1:0]  divCnt;
  logic [pDivWidth-1:0]  divLat;
  logic [pLenWidth-1:0]  frmCnt;
  logic [pLenWidth-1:0]  lenLat;
  logic                  cpolLat;
  logic                  cphaLat;

  logic                  tick;
  logic                  accept;
  logic                  lastEdge;
  logic                  sampleEdge;
  logic                  shiftEdge;
  logic                  moreFrames;
  logic [pDataWidth-1:0] rxNext;
  logic [pCsNum-1:0]     csMask;

  assign oWdRdy = iSpiEn && !iSysRst && !bufFull && (state != sHold);
  assign accept = iWdVd && oWdRdy;
  assign tick   = (divCnt == divLat);

  always_comb begin
    lastEdge   = (edgeCnt == cLastEdge);
    // CPHA=1 already has the MSB on the line, so edge 0 does not shift
    sampleEdge = cphaLat ? edgeCnt[0] : !edgeCnt[0];
    shiftEdge  = cphaLat ? (!edgeCnt[0] && (edgeCnt != '0))
                         : (edgeCnt[0] && !lastEdge);
    moreFrames = (frmCnt != lenLat);
    rxNext     = rxSh;
    if (sampleEdge)
      rxNext = {rxSh[pDataWidth-2:0], iMiso};
    csMask = ~(pCsNum'(1) << iCsSel);
  end

  always_ff @(posedge iSysClk or posedge iSysRst) begin
    if (iSysRst) begin
      state   <= sIdle;
      bufFull <= 1'b0;
      bufData <= '0;
      txSh    <= '0;
      rxSh    <= '0;
      edgeCnt <= '0;
      divCnt  <= '0;
      divLat  <= '0;
      frmCnt  <= '0;
      lenLat  <= '0;
      cpolLat <= 1'b0;
      cphaLat <= 1'b0;
      oRd     <= '0;
      oRdVd   <= 1'b0;
      oBusy   <= 1'b0;
      oDone   <= 1'b0;
      oSck    <= 1'b0;
      oMosi   <= 1'b1;
      oCs     <= '1;
    end else begin
      oRdVd <= 1'b0;
      oDone <= 1'b0;
      if (!iSpiEn) begin
        state   <= sIdle;
        bufFull <= 1'b0;
        divCnt  <= '0;
        oBusy   <= 1'b0;
        oSck    <= iCpol;
        oMosi   <= 1'b1;
        oCs     <= '1;
      end else begin
        if (accept && (state == sSetup || state == sXfer)) begin
          bufData <= iWd;
          bufFull <= 1'b1;
        end
        unique case (state)
          sIdle: begin
            divCnt <= '0;
            oSck   <= iCpol;
            oCs    <= '1;
            oMosi  <= 1'b1;
            if (accept) begin
              cpolLat <= iCpol;
              cphaLat <= iCpha;
              divLat  <= iDiv;
              lenLat  <= iLen;
              frmCnt  <= '0;
              edgeCnt <= '0;
              txSh    <= iWd;
              oMosi   <= iWd[pDataWidth-1];
              oCs     <= csMask;
              oBusy   <= 1'b1;
              state   <= sSetup;
            end
          end
          sSetup: begin
            divCnt <= tick ? '0 : divCnt + pDivWidth'(1);
            if (tick)
              state <= sXfer;
          end
          sXfer: begin
            divCnt <= tick ? '0 : divCnt + pDivWidth'(1);
            if (tick) begin
              oSck <= ~oSck;
              rxSh <= rxNext;
              if (shiftEdge) begin
                txSh  <= txSh << 1;
                oMosi <= txSh[pDataWidth-2];
              end
              if (lastEdge) begin
                oRd     <= rxNext;
                oRdVd   <= 1'b1;
                edgeCnt <= '0;
                if (moreFrames) begin
                  frmCnt <= frmCnt + pLenWidth'(1);
                  if (bufFull) begin
                    txSh    <= bufData;
                    oMosi   <= bufData[pDataWidth-1];
                    bufFull <= 1'b0;
                  end else begin
                    oMosi <= 1'b1;
                    state <= sStall;
                  end
                end else begin
                  oMosi <= 1'b1;
                  state <= sHold;
                end
              end else begin
                edgeCnt <= edgeCnt + cEdgeW'(1);
              end
            end
          end
          sStall: begin
            divCnt <= '0;
            oSck   <= cpolLat;
            if (accept) begin
              txSh    <= iWd;
              oMosi   <= iWd[pDataWidth-1];
              edgeCnt <= '0;
              state   <= sSetup;
            end
          end
          sHold: begin
            divCnt <= tick ? '0 : divCnt + pDivWidth'(1);
            if (tick) begin
              oCs   <= '1;
              oDone <= 1'b1;
              oBusy <= 1'b0;
              state <= sIdle;
            end
          end
          default: state <= sIdle;
        endcase
      end
    end
  end

endmodule
